// File: rtl/ctrl_word_encoder.sv
// ctrl_word_encoder: maps 6-bit control words back to instruction codes into a small FIFO.
// Optional saturating illegal-word counter enabled by CTRL_ENC_ERRCNT_EN.
module ctrl_word_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_code,
  output logic                     err,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [5:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [5:0] last_q, last_d, code;
  logic err_q, err_d, legal, acc, wr_en, drn;
  always_comb begin
    legal = 1'b1;
    code = '0;
    casez (in_word)
      6'b??0001: code = {4'b0000, in_word[5:4]};
      6'b??0011: code = {4'b0001, in_word[5:4]};
      6'b000100: code = 6'b001100;
      6'b001000: code = 6'b010001;
      6'b001010: code = 6'b011001;
      6'b001011: code = 6'b010101;
      6'b001111: code = 6'b011101;
      default:   legal = 1'b0;
    endcase
  end
  assign in_ready  = rst_n && (count_q != FULL);
  assign out_valid = count_q != '0;
  // once empty, the output shows the most recently drained entry
  assign out_code  = out_valid ? mem_q[rd_q] : last_q;
  assign err       = err_q;
  assign count     = count_q;
  always_comb begin
    acc     = in_valid && in_ready;
    wr_en   = acc && legal;
    drn     = out_valid && out_ready;
    wr_d    = wr_q + PW'(wr_en);
    rd_d    = rd_q + PW'(drn);
    count_d = count_q + CW'(wr_en) - CW'(drn);
    last_d  = drn ? mem_q[rd_q] : last_q;
    err_d   = acc && !legal;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= code;
  end
`ifdef CTRL_ENC_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (err_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_word_encoder.sv
// tb_ctrl_word_encoder: scoreboard bench for ctrl_word_encoder with directed vectors.
module tb_ctrl_word_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [5:0] in_word, out_code;
  logic [CNT_W-1:0] err_cnt;
  logic [$clog2(DEPTH):0] count;
  int checks = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic [5:0] q [$];
  logic [5:0] lw [13] = '{6'b000001, 6'b010001, 6'b100001, 6'b110001,
                          6'b000011, 6'b010011, 6'b100011, 6'b110011,
                          6'b000100, 6'b001000, 6'b001010, 6'b001011, 6'b001111};
  logic [5:0] lc [13] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
                          6'b000100, 6'b000101, 6'b000110, 6'b000111,
                          6'b001100, 6'b010001, 6'b011001, 6'b010101, 6'b011101};

  ctrl_word_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .err(err), .err_cnt(err_cnt), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lookup(input logic [5:0] w, output logic [5:0] c);
    c = '0;
    for (int i = 0; i < 13; i++) if (lw[i] == w) begin c = lc[i]; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic int exp_errcnt();
`ifdef CTRL_ENC_ERRCNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out got=%b exp=none", out_code);
      end else chk("out_code", 32'(out_code), 32'(q.pop_front()));
    end
  end

  task automatic send(input logic [5:0] w);
    logic [5:0] c;
    bit ok;
    int n = 0;
    ok = lookup(w, c);
    in_valid = 1'b1;
    in_word = w;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (ok) q.push_back(c);
    else if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    @(negedge clk);
    chk("err", 32'(err), 32'(!ok));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || count != 0) && n < 200) begin @(negedge clk); n++; end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_code", 32'(out_code), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_count", 32'(count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    // all 13 legal words streamed
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(lw[i]);
      if (i == 0) chk("latency_out_valid", 32'(out_valid), 1);
    end
    wait_drain();
    // fill to full, fifth word held
    out_ready = 1'b0;
    send(6'b000001); send(6'b000011); send(6'b000100); send(6'b001000);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    in_valid = 1'b1; in_word = 6'b001111;
    repeat (2) @(negedge clk);
    chk("held_count", 32'(count), 4);
    chk("stall_out_code", 32'(out_code), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("no_bypass_count", 32'(count), 3);
    send(6'b001111);
    wait_drain();
    // illegal word in the middle
    send(6'b010001); send(6'b111111); send(6'b001010);
    wait_drain();
    chk("err_cnt_one", 32'(err_cnt), 32'(exp_errcnt()));
    // saturation
    repeat (300) send(6'b111111);
    chk("sat_count", 32'(count), 0);
    chk("sat_err_cnt", 32'(err_cnt), 32'(exp_errcnt()));
    // reset mid-operation
    out_ready = 1'b0;
    send(6'b000001); send(6'b000011); send(6'b000100);
    chk("pre_rst_count", 32'(count), 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_code", 32'(out_code), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    q.delete();
    exp_cnt = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_after", 32'(in_ready), 1);
    // simultaneous accept/drain at count=2 across pointer wrap
    send(6'b110001); send(6'b110011);
    chk("sim_count0", 32'(count), 2);
    out_ready = 1'b1;
    send(6'b001011); chk("sim_count1", 32'(count), 2);
    send(6'b000001); chk("sim_count2", 32'(count), 2);
    send(6'b001000); chk("sim_count3", 32'(count), 2);
    wait_drain();
    chk("final_queue", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
